// File: rtl/dsp_aw_channel_pkg.sv
// Shared interconnect helpers: AW payload width and the address-to-slave decode.
package dsp_aw_channel_pkg;

    function automatic int aw_info_w(input int id_w, input int addr_w, input int burst_w,
                                     input int len_w, input int size_w);
        return id_w + addr_w + burst_w + len_w + size_w;
    endfunction

    // Payload width for the default interconnect configuration
    localparam int AW_INFO_W = aw_info_w(5, 32, 2, 3, 3);

    function automatic logic [31:0] slv_decode(input logic [63:0] addr, input int msb,
                                               input int lsb);
        logic [63:0] mask;
        mask = (64'd1 << (msb - lsb + 1)) - 64'd1;
        return 32'((addr >> lsb) & mask);
    endfunction

endpackage

// File: rtl/fifo.sv
// Synchronous FIFO with a combinational head output (no read latency).
module fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  empty,
    output logic                  full
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W:0]        wr_ptr;
    logic [PTR_W:0]        rd_ptr;

    // Extra pointer MSB distinguishes full from empty when the indices match
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign rd_data = mem[rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every flop updating from pre-edge values.
            if (push && !full)  wr_ptr <= wr_ptr + 1'b1;
            if (pop  && !empty) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: storage is not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push && !full) mem[wr_ptr[PTR_W-1:0]] <= wr_data;
    end

endmodule

// File: rtl/dsp_aw_channel.sv
// AW dispatcher for one master port: buffers AW requests, decodes the target slave,
// forwards to that slave and bounds the number of writes awaiting a B response.
module dsp_aw_channel
    import dsp_aw_channel_pkg::*;
#(
    parameter int SLV_AMT           = 2,
    parameter int OUTSTANDING_AMT   = 8,
    parameter int AW_FIFO_DEPTH     = 4,
    parameter int ADDR_WIDTH        = 32,
    parameter int TRANS_MST_ID_W    = 5,
    parameter int TRANS_BURST_W     = 2,
    parameter int TRANS_DATA_LEN_W  = 3,
    parameter int TRANS_DATA_SIZE_W = 3,
    parameter int SLV_ID_W          = $clog2(SLV_AMT),
    parameter int SLV_ID_MSB_IDX    = 30,
    parameter int SLV_ID_LSB_IDX    = 30
) (
    input  logic                                   ACLK_i,
    input  logic                                   ARESETn_i,
    input  logic [TRANS_MST_ID_W-1:0]              m_AWID_i,
    input  logic [ADDR_WIDTH-1:0]                  m_AWADDR_i,
    input  logic [TRANS_BURST_W-1:0]               m_AWBURST_i,
    input  logic [TRANS_DATA_LEN_W-1:0]            m_AWLEN_i,
    input  logic [TRANS_DATA_SIZE_W-1:0]           m_AWSIZE_i,
    input  logic                                   m_AWVALID_i,
    output logic                                   m_AWREADY_o,
    output logic [TRANS_MST_ID_W*SLV_AMT-1:0]      sa_AWID_o,
    output logic [ADDR_WIDTH*SLV_AMT-1:0]          sa_AWADDR_o,
    output logic [TRANS_BURST_W*SLV_AMT-1:0]       sa_AWBURST_o,
    output logic [TRANS_DATA_LEN_W*SLV_AMT-1:0]    sa_AWLEN_o,
    output logic [TRANS_DATA_SIZE_W*SLV_AMT-1:0]   sa_AWSIZE_o,
    output logic [SLV_AMT-1:0]                     sa_AWVALID_o,
    input  logic [SLV_AMT-1:0]                     sa_AWREADY_i,
    input  logic                                   dsp_B_done_i,
    output logic [SLV_ID_W-1:0]                    dsp_AW_slv_id_o,
    output logic                                   dsp_AW_shift_en_o
);
    localparam int INFO_W = aw_info_w(TRANS_MST_ID_W, ADDR_WIDTH, TRANS_BURST_W,
                                      TRANS_DATA_LEN_W, TRANS_DATA_SIZE_W);
    localparam int CNT_W  = $clog2(OUTSTANDING_AMT + 1);

    logic [INFO_W-1:0]            push_info;
    logic [INFO_W-1:0]            head_info;
    logic [INFO_W-1:0]            head_gated;
    logic [TRANS_MST_ID_W-1:0]    head_id;
    logic [ADDR_WIDTH-1:0]        head_addr;
    logic [TRANS_BURST_W-1:0]     head_burst;
    logic [TRANS_DATA_LEN_W-1:0]  head_len;
    logic [TRANS_DATA_SIZE_W-1:0] head_size;
    logic [SLV_ID_W-1:0]          slv_sel;
    logic [CNT_W-1:0]             out_cnt;
    logic                         fifo_empty;
    logic                         fifo_full;
    logic                         push;
    logic                         issue_ok;
    logic                         fwd;
    logic                         rst_done;

    assign m_AWREADY_o = rst_done & ~fifo_full;
    assign push        = m_AWVALID_i & m_AWREADY_o;
    assign push_info   = {m_AWID_i, m_AWADDR_i, m_AWBURST_i, m_AWLEN_i, m_AWSIZE_i};

    fifo #(
        .DATA_WIDTH (INFO_W),
        .FIFO_DEPTH (AW_FIFO_DEPTH)
    ) u_aw_fifo (
        .clk     (ACLK_i),
        .rst_n   (ARESETn_i),
        .push    (push),
        .wr_data (push_info),
        .pop     (fwd),
        .rd_data (head_info),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    // Zero the head while empty so stale storage never reaches the slave buses or slave ID
    assign head_gated = fifo_empty ? '0 : head_info;
    assign {head_id, head_addr, head_burst, head_len, head_size} = head_gated;
    assign slv_sel = SLV_ID_W'(slv_decode(64'(head_addr), SLV_ID_MSB_IDX, SLV_ID_LSB_IDX));

    assign issue_ok = ~fifo_empty & (out_cnt < CNT_W'(OUTSTANDING_AMT));
    assign fwd      = issue_ok & sa_AWREADY_i[slv_sel];

    always_comb begin
        // NOTE: default first so no path leaves a bit unassigned (no latch).
        sa_AWVALID_o          = '0;
        sa_AWVALID_o[slv_sel] = issue_ok;
    end

    assign sa_AWID_o         = {SLV_AMT{head_id}};
    assign sa_AWADDR_o       = {SLV_AMT{head_addr}};
    assign sa_AWBURST_o      = {SLV_AMT{head_burst}};
    assign sa_AWLEN_o        = {SLV_AMT{head_len}};
    assign sa_AWSIZE_o       = {SLV_AMT{head_size}};
    assign dsp_AW_slv_id_o   = slv_sel;
    assign dsp_AW_shift_en_o = fwd;

    always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
        if (!ARESETn_i) rst_done <= 1'b0;
        else            rst_done <= 1'b1;
    end

    always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
        if (!ARESETn_i) begin
            out_cnt <= '0;
        end else begin
            unique case ({fwd, dsp_B_done_i})
                2'b10:   out_cnt <= out_cnt + CNT_W'(1);
                2'b01:   if (out_cnt != '0) out_cnt <= out_cnt - CNT_W'(1);
                default: out_cnt <= out_cnt;
            endcase
        end
    end

    // A B completion with nothing outstanding means the B dispatcher lost track
    b_done_has_outstanding: assert property (
        @(posedge ACLK_i) disable iff (!ARESETn_i) dsp_B_done_i |-> (out_cnt != '0));

endmodule

// File: tb/tb_dsp_aw_channel.sv
// Self-checking bench for dsp_aw_channel: directed scenarios plus random traffic
// compared every cycle against a queue-based model of the dispatcher.
module tb_dsp_aw_channel;

    typedef struct packed {
        logic [4:0]  id;
        logic [31:0] addr;
        logic [1:0]  burst;
        logic [2:0]  len;
        logic [2:0]  size;
    } aw_t;

    logic        ACLK_i = 1'b0;
    logic        ARESETn_i;
    logic [4:0]  m_AWID_i;
    logic [31:0] m_AWADDR_i;
    logic [1:0]  m_AWBURST_i;
    logic [2:0]  m_AWLEN_i;
    logic [2:0]  m_AWSIZE_i;
    logic        m_AWVALID_i;
    logic        m_AWREADY_o;
    logic [9:0]  sa_AWID_o;
    logic [63:0] sa_AWADDR_o;
    logic [3:0]  sa_AWBURST_o;
    logic [5:0]  sa_AWLEN_o;
    logic [5:0]  sa_AWSIZE_o;
    logic [1:0]  sa_AWVALID_o;
    logic [1:0]  sa_AWREADY_i;
    logic        dsp_B_done_i;
    logic [0:0]  dsp_AW_slv_id_o;
    logic        dsp_AW_shift_en_o;

    dsp_aw_channel dut (
        .ACLK_i            (ACLK_i),
        .ARESETn_i         (ARESETn_i),
        .m_AWID_i          (m_AWID_i),
        .m_AWADDR_i        (m_AWADDR_i),
        .m_AWBURST_i       (m_AWBURST_i),
        .m_AWLEN_i         (m_AWLEN_i),
        .m_AWSIZE_i        (m_AWSIZE_i),
        .m_AWVALID_i       (m_AWVALID_i),
        .m_AWREADY_o       (m_AWREADY_o),
        .sa_AWID_o         (sa_AWID_o),
        .sa_AWADDR_o       (sa_AWADDR_o),
        .sa_AWBURST_o      (sa_AWBURST_o),
        .sa_AWLEN_o        (sa_AWLEN_o),
        .sa_AWSIZE_o       (sa_AWSIZE_o),
        .sa_AWVALID_o      (sa_AWVALID_o),
        .sa_AWREADY_i      (sa_AWREADY_i),
        .dsp_B_done_i      (dsp_B_done_i),
        .dsp_AW_slv_id_o   (dsp_AW_slv_id_o),
        .dsp_AW_shift_en_o (dsp_AW_shift_en_o)
    );

    always #5 ACLK_i = ~ACLK_i;

    int  n_checks = 0;
    int  n_errors = 0;
    aw_t mq[$];
    int  m_cnt;
    bit  m_rst_done;
    bit  e_ready;
    bit  e_shift;
    aw_t cur;
    int  accepts;
    int  shifts;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_cnt      = 0;
        m_rst_done = 0;
    endtask

    // Expected outputs derived from the queue contents and the outstanding count
    task automatic compare();
        aw_t         h;
        logic [1:0]  ev;
        logic        sel;
        logic [89:0] ep;
        logic [89:0] ap;
        h       = '0;
        ev      = '0;
        sel     = 1'b0;
        e_shift = 0;
        e_ready = m_rst_done && (mq.size() < 4);
        if (mq.size() > 0) begin
            h   = mq[0];
            sel = h.addr[30];
            if (m_cnt < 8) begin
                ev      = (sel ? 2'b10 : 2'b01);
                e_shift = sa_AWREADY_i[sel];
            end
        end
        ep = {{2{h.id}}, {2{h.addr}}, {2{h.burst}}, {2{h.len}}, {2{h.size}}};
        ap = {sa_AWID_o, sa_AWADDR_o, sa_AWBURST_o, sa_AWLEN_o, sa_AWSIZE_o};
        check("awready", m_AWREADY_o, e_ready);
        check("sa_valid", sa_AWVALID_o, ev);
        check("shift_en", dsp_AW_shift_en_o, e_shift);
        check("slv_id", dsp_AW_slv_id_o, sel);
        check("payload", ap, ep);
    endtask

    task automatic drive(input bit rstn, input bit mv, input logic [31:0] addr,
                         input logic [1:0] srdy, input bit bd);
        @(negedge ACLK_i);
        cur.id       = 5'($urandom);
        cur.addr     = addr;
        cur.burst    = 2'($urandom);
        cur.len      = 3'($urandom);
        cur.size     = 3'($urandom);
        ARESETn_i    = rstn;
        m_AWVALID_i  = mv;
        m_AWID_i     = cur.id;
        m_AWADDR_i   = cur.addr;
        m_AWBURST_i  = cur.burst;
        m_AWLEN_i    = cur.len;
        m_AWSIZE_i   = cur.size;
        sa_AWREADY_i = srdy;
        dsp_B_done_i = bd;
        if (!rstn) model_reset();
        #1;
        compare();
    endtask

    task automatic tick();
        @(posedge ACLK_i);
        if (!ARESETn_i) begin
            model_reset();
        end else begin
            if (e_shift) void'(mq.pop_front());
            if (m_AWVALID_i && e_ready) mq.push_back(cur);
            if (e_shift && !dsp_B_done_i) m_cnt++;
            else if (!e_shift && dsp_B_done_i && m_cnt > 0) m_cnt--;
            m_rst_done = 1;
        end
    endtask

    task automatic cyc(input bit rstn, input bit mv, input logic [31:0] addr,
                       input logic [1:0] srdy, input bit bd);
        drive(rstn, mv, addr, srdy, bd);
        tick();
    endtask

    task automatic do_reset();
        cyc(0, 1, $urandom, 2'b11, 0);
        cyc(0, 0, 0, 2'b00, 0);
        cyc(1, 0, 0, 2'b00, 0);
    endtask

    initial begin
        ARESETn_i    = 1'b0;
        m_AWVALID_i  = 1'b0;
        m_AWID_i     = '0;
        m_AWADDR_i   = '0;
        m_AWBURST_i  = '0;
        m_AWLEN_i    = '0;
        m_AWSIZE_i   = '0;
        sa_AWREADY_i = '0;
        dsp_B_done_i = 1'b0;
        model_reset();

        // Reset with the inputs toggling: everything must stay at zero
        for (int i = 0; i < 3; i++) begin
            drive(0, 1'($urandom), $urandom, 2'($urandom), 0);
            check("rst_awready", m_AWREADY_o, 1'b0);
            check("rst_valid", sa_AWVALID_o, 2'b00);
            tick();
        end
        drive(1, 0, 0, 2'b00, 0);
        check("release_awready", m_AWREADY_o, 1'b0);
        tick();
        drive(1, 1, 32'h4000_0000, 2'b00, 0);
        check("awready_rise", m_AWREADY_o, 1'b1);
        tick();
        drive(1, 0, 0, 2'b00, 0);
        check("first_valid", sa_AWVALID_o, 2'b10);
        check("first_slv_id", dsp_AW_slv_id_o, 1'b1);
        tick();
        drive(1, 0, 0, 2'b10, 0);
        check("first_fwd", dsp_AW_shift_en_o, 1'b1);
        tick();
        cyc(1, 0, 0, 2'b00, 1);

        // Back-to-back forwarding with both slaves ready
        drive(1, 1, 32'h0, 2'b11, 0);
        check("b2b_idle", dsp_AW_shift_en_o, 1'b0);
        tick();
        drive(1, 1, 32'h4000_0000, 2'b11, 0);
        check("b2b_shift0", dsp_AW_shift_en_o, 1'b1);
        check("b2b_id0", dsp_AW_slv_id_o, 1'b0);
        tick();
        drive(1, 1, 32'h0, 2'b11, 0);
        check("b2b_shift1", dsp_AW_shift_en_o, 1'b1);
        check("b2b_id1", dsp_AW_slv_id_o, 1'b1);
        tick();
        drive(1, 0, 0, 2'b11, 0);
        check("b2b_shift2", dsp_AW_shift_en_o, 1'b1);
        check("b2b_id2", dsp_AW_slv_id_o, 1'b0);
        tick();
        cyc(1, 0, 0, 2'b11, 0);
        do_reset();

        // Slave 0 stalls for 10 cycles: FIFO fills, payload holds, then drains
        accepts = 0;
        for (int i = 0; i < 10; i++) begin
            drive(1, 1, $urandom & 32'hBFFF_FFFF, 2'b10, 0);
            if (m_AWREADY_o) accepts++;
            tick();
        end
        check("bp_accepts", accepts, 4);
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 0, 2'b11, 0);
            check("bp_drain", dsp_AW_shift_en_o, 1'b1);
            tick();
        end
        drive(1, 0, 0, 2'b11, 0);
        check("bp_empty", dsp_AW_shift_en_o, 1'b0);
        tick();
        do_reset();

        // Outstanding cap without B responses
        shifts = 0;
        for (int i = 0; i < 20; i++) begin
            drive(1, 1, (i % 2) ? 32'h4000_0010 : 32'h0000_0020, 2'b11, 0);
            if (dsp_AW_shift_en_o) shifts++;
            tick();
        end
        check("cap_forwards", shifts, 8);
        drive(1, 1, 32'h0, 2'b11, 1);
        check("cap_valid_low", sa_AWVALID_o, 2'b00);
        tick();
        drive(1, 1, 32'h0, 2'b11, 0);
        check("cap_one_more", dsp_AW_shift_en_o, 1'b1);
        tick();
        drive(1, 1, 32'h0, 2'b11, 0);
        check("cap_full_again", sa_AWVALID_o, 2'b00);
        tick();
        cyc(1, 1, 32'h0, 2'b11, 1);
        drive(1, 1, 32'h0, 2'b11, 1);
        check("coincident_fwd", dsp_AW_shift_en_o, 1'b1);
        tick();
        drive(1, 1, 32'h0, 2'b11, 0);
        check("after_coincident", dsp_AW_shift_en_o, 1'b1);
        tick();
        drive(1, 0, 0, 2'b11, 0);
        check("cap_final", sa_AWVALID_o, 2'b00);
        tick();

        // Asynchronous reset while a valid is pending
        cyc(1, 0, 0, 2'b00, 1);
        drive(1, 0, 0, 2'b00, 0);
        check("pre_rst_valid", |sa_AWVALID_o, 1'b1);
        #2 ARESETn_i = 1'b0;
        #1;
        check("async_valid_drop", sa_AWVALID_o, 2'b00);
        check("async_awready_drop", m_AWREADY_o, 1'b0);
        model_reset();
        tick();
        cyc(0, 0, 0, 2'b00, 0);
        drive(1, 0, 0, 2'b11, 0);
        check("post_rst_awready", m_AWREADY_o, 1'b0);
        tick();
        drive(1, 0, 0, 2'b11, 0);
        check("post_rst_empty", sa_AWVALID_o, 2'b00);
        check("post_rst_ready", m_AWREADY_o, 1'b1);
        tick();

        // Random traffic, occasional resets, B completions only when legal
        for (int i = 0; i < 600; i++) begin
            bit rstn;
            bit bd;
            rstn = ($urandom_range(0, 149) != 0);
            bd   = (m_cnt > 0) && ($urandom_range(0, 2) == 0);
            cyc(rstn, 1'($urandom), $urandom, 2'($urandom), bd);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
